// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) receive controller and its correction core.
// Code position p (1..7) lives in word bit p-1 throughout.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SYND,
        CORR,
        OUT
    } state_t;

    // Code positions carrying data bits d0..d3, giving data = {pos7,pos6,pos5,pos3}.
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7};

    // Syndrome bit k covers every code position whose index has bit k set.
    localparam logic [CODE_W-1:0] SYN_MASK [SYN_W] = '{7'h55, 7'h66, 7'h78};

endpackage

// File: rtl/hamming_corr_core.sv
// Combinational Hamming(7,4) syndrome and single-bit correction, shared by both receive channels.
module hamming_corr_core
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] word,
    output logic [SYN_W-1:0]  err_pos,
    output logic [CODE_W-1:0] word_corr,
    output logic [DATA_W-1:0] data_corr
);

    genvar gi;

    generate
        for (gi = 0; gi < SYN_W; gi++) begin : g_syn
            assign err_pos[gi] = ^(word & SYN_MASK[gi]);
        end

        // A zero syndrome matches no position, so a clean word passes through untouched.
        for (gi = 0; gi < CODE_W; gi++) begin : g_fix
            assign word_corr[gi] = word[gi] ^ (err_pos == SYN_W'(gi + 1));
        end

        for (gi = 0; gi < DATA_W; gi++) begin : g_data
            assign data_corr[gi] = word_corr[DATA_POS[gi] - 1];
        end
    endgenerate

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Two-channel round-robin Hamming(7,4) receive controller: accept, syndrome, correct, present.
// Define HAMMING_ERR_CNT_EN to add the saturating err_cnt output of corrected words.
module hamming_rx_ctrl
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch0_valid,
    input  logic              ch1_valid,
    input  logic [CODE_W-1:0] ch0_word,
    input  logic [CODE_W-1:0] ch1_word,
    output logic              ch0_ready,
    output logic              ch1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CODE_W-1:0] out_word,
    output logic [SYN_W-1:0]  out_err_pos,
    output logic              out_ch,
    output logic              busy
`ifdef HAMMING_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    state_t              state_reg;
    logic [CODE_W-1:0]   word_reg;
    logic [SYN_W-1:0]    err_pos_reg;
    logic                prio_reg;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic [CODE_W-1:0]   out_word_reg;
    logic [SYN_W-1:0]    out_err_pos_reg;
    logic                out_ch_reg;

    logic [1:0]          valid_vec;
    logic [1:0]          ready_vec;
    logic [CODE_W-1:0]   word_vec [2];
    logic                gnt_any;
    logic                gnt_ch;
    logic                out_fire;

    logic [SYN_W-1:0]    core_err_pos;
    logic [CODE_W-1:0]   core_word_corr;
    logic [DATA_W-1:0]   core_data_corr;

    assign valid_vec   = {ch1_valid, ch0_valid};
    assign word_vec[0] = ch0_word;
    assign word_vec[1] = ch1_word;
    assign out_fire    = out_valid_reg && out_ready;

    // prio_reg names the channel that wins a tie; it flips away from every grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = 1'b0;
        if (valid_vec == 2'b11) begin
            gnt_any = 1'b1;
            gnt_ch  = prio_reg;
        end else if (valid_vec[0]) begin
            gnt_any = 1'b1;
            gnt_ch  = 1'b0;
        end else if (valid_vec[1]) begin
            gnt_any = 1'b1;
            gnt_ch  = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = rst_n && (state_reg == IDLE) && gnt_any && (gnt_ch == 1'(gi));
        end
    endgenerate

    assign ch0_ready = ready_vec[0];
    assign ch1_ready = ready_vec[1];

    hamming_corr_core u_core (
        .word      (word_reg),
        .err_pos   (core_err_pos),
        .word_corr (core_word_corr),
        .data_corr (core_data_corr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            word_reg        <= '0;
            err_pos_reg     <= '0;
            prio_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_word_reg    <= '0;
            out_err_pos_reg <= '0;
            out_ch_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_any) begin
                        word_reg   <= word_vec[gnt_ch];
                        out_ch_reg <= gnt_ch;
                        prio_reg   <= ~gnt_ch;
                        state_reg  <= SYND;
                    end
                end
                SYND: begin
                    err_pos_reg <= core_err_pos;
                    state_reg   <= CORR;
                end
                CORR: begin
                    out_word_reg    <= core_word_corr;
                    out_data_reg    <= core_data_corr;
                    out_err_pos_reg <= err_pos_reg;
                    out_valid_reg   <= 1'b1;
                    state_reg       <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_word    = out_word_reg;
    assign out_err_pos = out_err_pos_reg;
    assign out_ch      = out_ch_reg;
    assign busy        = (state_reg != IDLE);

`ifdef HAMMING_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (out_fire && (out_err_pos_reg != '0) && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    // Counter absent: corrected words are reported only through out_err_pos.
`endif

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Scoreboard bench for hamming_rx_ctrl: directed cases plus randomized two-channel traffic.
// Builds with or without HAMMING_ERR_CNT_EN; err_cnt checks follow the macro.
module tb_hamming_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld [2];
    logic [6:0] wrd [2];
    logic       ch0_ready, ch1_ready;
    logic       out_valid, out_ready;
    logic [3:0] out_data;
    logic [6:0] out_word;
    logic [2:0] out_err_pos;
    logic       out_ch, busy;
`ifdef HAMMING_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    hamming_rx_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch0_valid   (vld[0]),
        .ch1_valid   (vld[1]),
        .ch0_word    (wrd[0]),
        .ch1_word    (wrd[1]),
        .ch0_ready   (ch0_ready),
        .ch1_ready   (ch1_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_word    (out_word),
        .out_err_pos (out_err_pos),
        .out_ch      (out_ch),
        .busy        (busy)
`ifdef HAMMING_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [6:0] word;
        logic [3:0] data;
        logic [2:0] pos;
        logic       ch;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    int         grant_log [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         err_model = 0;
    bit         pending = 0;
    bit         seen = 0;
    logic       last_ch = 1'b1;
    logic       acc [2];
    logic [6:0] last_word;
    logic [3:0] last_data;
    logic [2:0] last_pos;
    logic       last_och;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Syndrome of a Hamming code word is the XOR of the positions of its set bits.
    function automatic void ref_decode(input logic [6:0] w, output logic [6:0] wc,
                                       output logic [3:0] d, output logic [2:0] p);
        int s;
        s = 0;
        for (int i = 1; i <= 7; i++) if (w[i-1]) s = s ^ i;
        p  = 3'(s);
        wc = w;
        if (s != 0) wc[s-1] = ~wc[s-1];
        d = {wc[6], wc[5], wc[4], wc[2]};
    endfunction

    function automatic logic [6:0] make_word(input bit with_err);
        logic [6:0] w, wc;
        logic [3:0] d;
        logic [2:0] p;
        int b;
        w = 7'($urandom);
        ref_decode(w, wc, d, p);
        if (with_err) begin
            b = int'($urandom_range(6, 0));
            wc[b] = ~wc[b];
        end
        return wc;
    endfunction

    // Monitor: input handshakes feed the scoreboard, output cycles are checked against it.
    exp_t       m_e;
    logic       m_g;
    logic       m_exp_g;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            pending   = 0;
            seen      = 0;
            last_ch   = 1'b1;
            err_model = 0;
            acc[0]    = 1'b0;
            acc[1]    = 1'b0;
            continue;
        end
        cyc++;
        chk("dual_ready", 32'(ch0_ready & ch1_ready), 0);
        chk("busy", 32'(busy), 32'(pending));
        if (pending) chk("ready_while_busy", 32'(ch0_ready | ch1_ready), 0);
`ifdef HAMMING_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(err_model));
`endif
        acc[0] = vld[0] && ch0_ready;
        acc[1] = vld[1] && ch1_ready;
        if (ch0_ready || ch1_ready) begin
            chk("ready_needs_valid", 32'(vld[0] | vld[1]), 1);
            m_exp_g = (vld[0] && vld[1]) ? ~last_ch : vld[1];
            chk("grant", 32'(ch1_ready), 32'(m_exp_g));
        end
        if (acc[0] || acc[1]) begin
            m_g = acc[1];
            ref_decode(wrd[m_g], m_e.word, m_e.data, m_e.pos);
            m_e.ch  = m_g;
            m_e.cyc = cyc;
            sb.push_back(m_e);
            grant_log.push_back(int'(m_g));
            last_ch = m_g;
            pending = 1;
        end
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 0);
            end else begin
                m_e = sb[0];
                if (!seen) begin
                    chk("latency", 32'(cyc - m_e.cyc), 3);
                    seen = 1;
                end
                chk("out_word", 32'(out_word), 32'(m_e.word));
                chk("out_data", 32'(out_data), 32'(m_e.data));
                chk("out_err_pos", 32'(out_err_pos), 32'(m_e.pos));
                chk("out_ch", 32'(out_ch), 32'(m_e.ch));
                if (out_ready) begin
                    void'(sb.pop_front());
                    pending   = 0;
                    seen      = 0;
                    last_word = out_word;
                    last_data = out_data;
                    last_pos  = out_err_pos;
                    last_och  = out_ch;
                    if (m_e.pos != 0 && err_model < 255) err_model++;
                end
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ch0_ready", 32'(ch0_ready), 0);
        chk("rst_ch1_ready", 32'(ch1_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_word", 32'(out_word), 0);
        chk("rst_out_err_pos", 32'(out_err_pos), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
`ifdef HAMMING_ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 0);
`endif
    endtask

    task automatic send(input int ch, input logic [6:0] w);
        bit done;
        done = 0;
        @(posedge clk); #1;
        wrd[ch] = w;
        vld[ch] = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            if (acc[ch]) done = 1;
        end
        vld[ch] = 1'b0;
        if (!done) chk("send_timeout", 32'(done), 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            if (!pending && sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 32'(done), 1);
    endtask

    initial begin
        int base;
        bit hit;
        vld[0] = 1'b0; vld[1] = 1'b0;
        wrd[0] = '0;   wrd[1] = '0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        vld[0] = 1'b1; vld[1] = 1'b1;
        #2;
        check_reset_vals();
        vld[0] = 1'b0; vld[1] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Clean word on ch0.
        out_ready = 1'b1;
        send(0, 7'h55);
        wait_drain();
        chk("clean_word", 32'(last_word), 32'h55);
        chk("clean_data", 32'(last_data), 32'b1011);
        chk("clean_pos", 32'(last_pos), 0);
        chk("clean_ch", 32'(last_och), 0);

        // Single-bit error at position 5 on ch1.
        send(1, 7'h45);
        wait_drain();
        chk("err_word", 32'(last_word), 32'h55);
        chk("err_data", 32'(last_data), 32'b1011);
        chk("err_pos", 32'(last_pos), 5);
        chk("err_ch", 32'(last_och), 1);
`ifdef HAMMING_ERR_CNT_EN
        chk("err_cnt_one", 32'(err_cnt), 1);
`endif

        // Both channels requesting continuously: grants must alternate starting at ch0.
        base = grant_log.size();
        @(posedge clk); #1;
        wrd[0] = make_word(0); wrd[1] = make_word(1);
        vld[0] = 1'b1; vld[1] = 1'b1;
        for (int k = 0; k < 200 && grant_log.size() < base + 4; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) if (acc[i]) wrd[i] = make_word($urandom_range(1, 0) == 1);
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        chk("arb_count", 32'(grant_log.size() - base), 4);
        for (int j = 0; j < 4 && base + j < grant_log.size(); j++)
            chk("arb_order", 32'(grant_log[base+j]), 32'(j % 2));
        wait_drain();

        // Backpressure: hold OUT for 5 cycles with ch1 waiting, then one handshake.
        out_ready = 1'b0;
        send(0, make_word(1));
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(posedge clk); #1;
            if (out_valid) hit = 1;
        end
        chk("bp_out_valid", 32'(hit), 1);
        wrd[1] = make_word(0);
        vld[1] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_no_accept", 32'(ch1_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", 32'(out_valid), 0);
        chk("bp_idle", 32'(busy), 0);
        chk("bp_next_ready", 32'(ch1_ready), 1);
        @(posedge clk); #1;
        vld[1] = 1'b0;
        wait_drain();

        // Reset while the accepted word sits in SYND.
        @(posedge clk); #1;
        wrd[0] = 7'h45;
        vld[0] = 1'b1;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(posedge clk); #1;
            if (acc[0]) hit = 1;
        end
        chk("rst_accept", 32'(hit), 1);
        chk("rst_in_synd_busy", 32'(busy), 1);
        vld[1] = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        vld[0] = 1'b0; vld[1] = 1'b0;
        #4;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("no_out_after_rst", 32'(out_valid), 0);
        end

        // Randomized traffic with drops and random backpressure.
        for (int c = 0; c < 1200; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (vld[i] && acc[i]) begin
                    vld[i] = ($urandom_range(1, 0) == 1);
                    wrd[i] = make_word($urandom_range(1, 0) == 1);
                end else if (vld[i] && $urandom_range(15, 0) == 0) begin
                    vld[i] = 1'b0;
                end else if (!vld[i] && $urandom_range(2, 0) == 0) begin
                    vld[i] = 1'b1;
                    wrd[i] = make_word($urandom_range(1, 0) == 1);
                end
            end
            out_ready = ($urandom_range(3, 0) != 0);
        end
        vld[0] = 1'b0; vld[1] = 1'b0;
        out_ready = 1'b1;
        wait_drain();

`ifdef HAMMING_ERR_CNT_EN
        for (int n = 0; n < 260; n++) send(n % 2, make_word(1));
        wait_drain();
        chk("err_cnt_saturated", 32'(err_cnt), 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hamming_rx_ctrl.md
HAMMING_RX_CTRL -- requirements
Module: hamming_rx_ctrl

Interface
REQ-001 SHALL have ports, in order, clk (input, 1): single rising-edge clock; rst_n (input, 1): reset, asynchronous, active-low.
REQ-002 SHALL have ch0_valid, ch1_valid (input, 1 each): requester has a received word.
REQ-003 SHALL have ch0_word, ch1_word (input, 7 each): received Hamming(7,4) word; bit i-1 is code position i.
REQ-004 SHALL have ch0_ready, ch1_ready (output, 1 each): word accepted this cycle when valid and ready are both high.
REQ-005 SHALL have out_valid (output, 1), out_ready (input, 1): result handshake.
REQ-006 SHALL have out_data (output, 4): corrected data {pos7,pos6,pos5,pos3}.
REQ-007 SHALL have out_word (output, 7), out_err_pos (output, 3, 0 = no error), out_ch (output, 1): corrected word, corrected position, source channel.
REQ-008 SHALL have busy (output, 1): FSM not in IDLE.
REQ-009 SHALL have err_cnt (output, 8): saturating count of corrected words, present only when HAMMING_ERR_CNT_EN is defined.

Function
REQ-010 SHALL implement FSM states IDLE, SYND, CORR, OUT.
REQ-011 In IDLE, SHALL grant one requester by round-robin, accept its word into a 7-bit register and its id into out_ch, and move to SYND.
REQ-012 On simultaneous valid, SHALL grant the channel not granted last; after reset ch0 has priority.
REQ-013 SHALL assert at most one chN_ready per cycle, only in IDLE, and only to the granted channel; ready SHALL NOT depend combinationally on out_ready.
REQ-014 In SYND, SHALL register the syndrome: s0 = p1^p3^p5^p7, s1 = p2^p3^p6^p7, s2 = p4^p5^p6^p7, err_pos = {s2,s1,s0}; then go to CORR.
REQ-015 In CORR, SHALL register out_word = word XOR (1 << (err_pos-1)) when err_pos != 0, else word unchanged, plus out_data and out_err_pos; then go to OUT.
REQ-016 In OUT, SHALL hold out_valid high and all out_* stable until out_ready; on the handshake cycle SHALL return to IDLE.
REQ-017 Latency: accept in cycle N gives out_valid high from cycle N+3; with out_ready tied high, throughput is one word per 4 cycles.
REQ-018 Next acceptance SHALL occur no earlier than the cycle after the output handshake.
REQ-019 A request whose valid drops before grant SHALL be dropped without side effects.
REQ-020 Outputs while out_valid is low are don't-care but SHALL be deterministic.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, out_valid=0, ch0_ready=ch1_ready=0, busy=0, out_data=0, out_word=0, out_err_pos=0, out_ch=0, round-robin pointer=ch0, and err_cnt=0 if present.
REQ-022 Reset mid-operation SHALL discard the in-flight word with no output handshake; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-023 With HAMMING_ERR_CNT_EN defined, err_cnt SHALL increment by 1 on each output handshake with out_err_pos != 0 and saturate at 8'hFF.
REQ-024 Without HAMMING_ERR_CNT_EN, the err_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 Shared package hamming_pkg SHALL hold the FSM state enum, code word width 7, data width 4, syndrome width 3, and the data-bit extraction position constants.
REQ-026 The syndrome and correction logic SHALL be a sub-module hamming_corr_core (word in; err_pos, word_corr, data_corr out), instantiated once and shared by both channels.

Verification
REQ-027 Clean word: ch0 sends 7'h55 -> out_data=4'b1011, out_word=7'h55, out_err_pos=0, out_ch=0, out_valid at N+3.
REQ-028 Single error: ch1 sends 7'h45 -> out_err_pos=5, out_word=7'h55, out_data=4'b1011, out_ch=1; err_cnt increments from 0 to 1 (macro on).
REQ-029 Arbitration: both channels valid continuously for 4 words -> grant order ch0, ch1, ch0, ch1; no simultaneous readys.
REQ-030 Backpressure: out_ready low for 5 cycles in OUT -> outputs stable, no new acceptance; then a single handshake and return to IDLE.
REQ-031 Reset in SYND: rst_n pulsed low -> all outputs at reset values asynchronously; no out_valid for the discarded word.
REQ-032 Saturation: 256 erroneous words -> err_cnt holds 8'hFF; the macro-off build compiles without the err_cnt port.
